// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states, derived widths and line metadata for set_assoc_cache
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT} state_t;
  typedef struct packed {
    logic valid;
    logic dirty;
    logic [31:0] tag;
  } meta_t;
  function automatic int off_w(input int line_size);
    return $clog2(line_size / 4);
  endfunction
  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction
  function automatic int tag_w(input int line_size, input int num_sets);
    return 32 - off_w(line_size) - idx_w(num_sets);
  endfunction
  function automatic int age_w(input int num_ways);
    return num_ways > 1 ? $clog2(num_ways) : 1;
  endfunction
endpackage

// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if: memory-side request/response bus of the cache
// master (cache) drives mem_req_*, samples mem_ready/mem_resp_*; slave (memory) is the reverse
interface set_assoc_cache_if #(
  parameter int LINE_SIZE = 16
);
  logic mem_req_valid;
  logic mem_req_write;
  logic [31:0] mem_req_addr;
  logic [LINE_SIZE*8-1:0] mem_req_data;
  logic mem_ready;
  logic mem_resp_valid;
  logic [LINE_SIZE*8-1:0] mem_resp_data;
  modport master(
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    input mem_ready, mem_resp_valid, mem_resp_data
  );
  modport slave(
    input mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
    output mem_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/cache_lru.sv
// cache_lru: per-set true-LRU ages, victim selection and age update on access
// Ports: clk, reset; idx/valid select the set and its valid bits -> victim; upd/way record an access to idx
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  localparam int IDX = idx_w(NUM_SETS),
  localparam int AGE_W = age_w(NUM_WAYS)
) (
  input logic clk,
  input logic reset,
  input logic [IDX-1:0] idx,
  input logic [NUM_WAYS-1:0] valid,
  output logic [AGE_W-1:0] victim,
  input logic upd,
  input logic [AGE_W-1:0] way
);
  logic [AGE_W-1:0] age [NUM_SETS][NUM_WAYS];
  // Lowest invalid way wins; otherwise the oldest way (age NUM_WAYS-1).
  always_comb begin
    victim = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (age[idx][w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid[w]) victim = AGE_W'(w);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (upd) begin
      for (int w = 0; w < NUM_WAYS; w++)
        if (AGE_W'(w) == way) age[idx][w] <= '0;
        else if (age[idx][w] < age[idx][way]) age[idx][w] <= age[idx][w] + 1'b1;
    end
  end
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-back, write-allocate cache with true-LRU replacement
// Ports: clk, reset; CPU side is_input_valid/addr/mem_read/mem_write/din -> is_ready/is_output_valid/dout/is_hit;
// memory side via set_assoc_cache_if.master. Defining CACHE_STATS_EN adds hit_count/miss_count outputs.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2
) (
  input logic clk,
  input logic reset,
  input logic is_input_valid,
  input logic [31:0] addr,
  input logic mem_read,
  input logic mem_write,
  input logic [31:0] din,
  output logic is_ready,
  output logic is_output_valid,
  output logic [31:0] dout,
  output logic is_hit,
`ifdef CACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  set_assoc_cache_if.master mem
);
  localparam int OFF = off_w(LINE_SIZE);
  localparam int IDX = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(LINE_SIZE, NUM_SETS);
  localparam int AGE_W = age_w(NUM_WAYS);
  localparam int LINE_BITS = LINE_SIZE * 8;
  state_t state, state_n;
  meta_t meta [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data [NUM_SETS][NUM_WAYS];
  logic [31:0] req_addr, req_din;
  logic req_write, missed, hit, accept, hit_done, fill_done;
  logic [AGE_W-1:0] vic, lru_victim, hit_way;
  logic [NUM_WAYS-1:0] set_valid;
  logic [IDX-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF-1:0] off;
  assign idx = req_addr[OFF+IDX-1:OFF];
  assign tag = req_addr[31:OFF+IDX];
  assign off = req_addr[OFF-1:0];
  assign is_ready = state == IDLE;
  assign accept = is_input_valid && is_ready;
  assign hit_done = state == LOOKUP && hit;
  assign fill_done = state == FILL_WAIT && mem.mem_resp_valid;
  assign mem.mem_req_valid = state inside {WB_REQ, FILL_REQ};
  assign mem.mem_req_write = state == WB_REQ;
  assign mem.mem_req_addr = {state == WB_REQ ? meta[idx][vic].tag[TAG_W-1:0] : tag, idx, {OFF{1'b0}}};
  assign mem.mem_req_data = data[idx][vic];
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    set_valid = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      set_valid[w] = meta[idx][w].valid;
      if (meta[idx][w].valid && meta[idx][w].tag == 32'(tag)) begin
        hit = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end
  cache_lru #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) u_lru (
    .clk(clk),
    .reset(reset),
    .idx(idx),
    .valid(set_valid),
    .victim(lru_victim),
    .upd(hit_done),
    .way(hit_way)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept && (mem_read || mem_write)) state_n = LOOKUP;
      LOOKUP: state_n = hit ? IDLE : (meta[idx][lru_victim].valid && meta[idx][lru_victim].dirty) ? WB_REQ : FILL_REQ;
      WB_REQ: if (mem.mem_ready) state_n = FILL_REQ;
      FILL_REQ: if (mem.mem_ready) state_n = FILL_WAIT;
      FILL_WAIT: if (mem.mem_resp_valid) state_n = LOOKUP;
      default: state_n = IDLE;
    endcase
  end
  // A miss replays LOOKUP after the fill, so "missed" remembers that the completing hit was not a first-lookup hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_output_valid <= 1'b0;
      is_hit <= 1'b0;
      dout <= '0;
      missed <= 1'b0;
      vic <= '0;
      req_addr <= '0;
      req_din <= '0;
      req_write <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          meta[s][w] <= '0;
    end else begin
      is_output_valid <= 1'b0;
      if (accept) begin
        req_addr <= addr;
        req_din <= din;
        req_write <= mem_write;
        if (!mem_read && !mem_write) begin
          is_output_valid <= 1'b1;
          is_hit <= 1'b1;
        end
      end
      if (hit_done) begin
        is_output_valid <= 1'b1;
        is_hit <= !missed;
        missed <= 1'b0;
        if (req_write) meta[idx][hit_way].dirty <= 1'b1;
        else dout <= data[idx][hit_way][32*off +: 32];
      end
      if (state == LOOKUP && !hit) begin
        missed <= 1'b1;
        vic <= lru_victim;
      end
      if (fill_done) meta[idx][vic] <= '{valid: 1'b1, dirty: 1'b0, tag: 32'(tag)};
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && hit_done && req_write) data[idx][hit_way][32*off +: 32] <= req_din;
    if (!reset && fill_done) data[idx][vic] <= mem.mem_resp_data;
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (hit_done) begin
      if (missed) miss_count <= miss_count + 32'd1;
      else hit_count <= hit_count + 32'd1;
    end
  end
`endif
endmodule

// File: doc/set_assoc_cache.md
Name: set_assoc_cache

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement, placed between the CPU datapath and the block-wide data memory.
Replaces the direct-mapped data cache with a clocked FSM and an explicit memory-side handshake; the data memory is external to this block.
Serves one outstanding request at a time. Reports hit/miss per access.

Parameters:
LINE_SIZE, 16, line size in bytes (power of 2, >=8); WORDS = LINE_SIZE/4
NUM_SETS, 16, number of sets (power of 2, >=2)
NUM_WAYS, 2, associativity (power of 2, 1..8)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
is_input_valid  input  1  CPU request valid
addr  input  32  word address: offset=addr[OFF-1:0], index=addr[OFF+IDX-1:OFF], tag=rest (OFF=CLOG2(WORDS), IDX=CLOG2(NUM_SETS))
mem_read  input  1  load request
mem_write  input  1  store request
din  input  32  store data
is_ready  output  1  cache can accept a request (state IDLE)
is_output_valid  output  1  one-cycle pulse: request complete
dout  output  32  load data, valid with is_output_valid
is_hit  output  1  completed access hit on first lookup, valid with is_output_valid
mem_req_valid  output  1  memory request valid
mem_req_write  output  1  1=write-back, 0=line fill
mem_req_addr  output  32  line-aligned word address
mem_req_data  output  LINE_SIZE*8  victim line data
mem_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  fill data valid, one-cycle pulse
mem_resp_data  input  LINE_SIZE*8  fill line data

Behaviour:
- Reset (clk edge with reset=1): all valid/dirty bits 0, LRU ages set to way index, state IDLE, is_output_valid=0, is_hit=0, dout=0, mem_req_valid=0. Reset mid-miss abandons the transfer; mem_req_valid is 0 the cycle after reset. Late mem_resp_valid is ignored.
- Acceptance: request latched when is_input_valid && is_ready at a rising edge. Both mem_read and mem_write high is treated as a write. Neither high means no-op: is_output_valid=1, is_hit=1 next cycle, no state change.
- FSM states: IDLE, LOOKUP, WB_REQ, FILL_REQ, FILL_WAIT.
- IDLE -> LOOKUP on accept.
- LOOKUP, hit: load returns the word, or store writes the word and sets dirty. Update LRU, -> IDLE. Outputs are registered, so is_output_valid is high in the cycle after LOOKUP. Hit latency: 2 cycles from accept edge to output-valid cycle.
- LOOKUP, miss: choose victim = lowest-index invalid way, else the way with age NUM_WAYS-1. Latch the victim way for the whole miss. Dirty victim -> WB_REQ; clean victim -> FILL_REQ.
- WB_REQ: mem_req_valid=1, mem_req_write=1, mem_req_addr={victim tag, index, OFF'b0}, data = victim line. Stays until mem_ready=1 at an edge; the write is done on acceptance. -> FILL_REQ.
- FILL_REQ: mem_req_valid=1, mem_req_write=0, line-aligned request address. Held until mem_ready=1, -> FILL_WAIT.
- FILL_WAIT: on mem_resp_valid, install the line in the victim way (valid=1, dirty=0, new tag). -> LOOKUP replay, which now hits and completes with is_hit=0. A store miss merges din at replay and sets dirty.
- The memory-side request is stable and held while mem_req_valid=1 && !mem_ready. mem_resp_valid outside FILL_WAIT is ignored.
- LRU: per-set, per-way age of CLOG2(NUM_WAYS) bits. On access, the accessed way goes to 0 and ways younger than it increment. Ages within a set are always a permutation of 0..NUM_WAYS-1. NUM_WAYS=1: victim is always way 0.
- Outputs dout and is_hit hold their last values when is_output_valid=0.

Optional Feature:
Macro CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Exactly one of them increments per completed read/write (no-ops are not counted). Both clear on reset and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg: FSM state enum; derived widths (OFF, IDX, TAG_W, AGE_W) as functions of the parameters; line-metadata struct {valid, dirty, tag}.
- One sub-module, cache_lru: per-set age storage, victim select, and age update on access.

Test Plan:
- Cold read addr=0x40 (NUM_SETS=16, WAYS=2, LINE=16): one FILL request to addr 0x40; resp data word0=0xDEADBEEF -> dout=0xDEADBEEF, is_hit=0. Repeat read -> is_hit=1 at 2-cycle latency.
- Write 0x12345678 to 0x41 after fill -> is_hit=1; read 0x41 -> 0x12345678; no memory request issued.
- Read tags A=0x00, B=0x40, C=0x80 into set 0, then touch A, then read C again. The dirty-or-clean victim is B (LRU); A still hits afterwards.
- Dirty eviction: write 0x00, fill 0x40, read 0x80. Expect WB_REQ addr=0x00 carrying the written word, then FILL addr=0x80, with mem_ready held low 5 cycles and request fields stable throughout.
- Reset asserted during FILL_WAIT: next cycle is_ready=1 and mem_req_valid=0. A subsequent read of the same address misses.
- CACHE_STATS_EN: 3 misses and 4 hits plus 2 no-ops give hit_count=4, miss_count=3.
